// File: rtl/traffic_phase_fsm_pkg.sv
// traffic_pkg: phase encoding, lamp one-hot codes and dwell thresholds shared with the phase timer.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_R_M = 3'd0,
        MAIN_G  = 3'd1,
        MAIN_Y  = 3'd2,
        ALL_R_S = 3'd3,
        SIDE_G  = 3'd4,
        SIDE_Y  = 3'd5
    } state_t;

    // lamp bits ordered {r, y, g}
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam int unsigned T_RED    = 3;
    localparam int unsigned T_YEL    = 8;
    localparam int unsigned T_SIDE_G = 13;
    localparam int unsigned T_MAIN_G = 18;

    function automatic logic [5:0] lamps_of(input state_t s);
        return s == MAIN_G ? {LAMP_G, LAMP_R} :
               s == MAIN_Y ? {LAMP_Y, LAMP_R} :
               s == SIDE_G ? {LAMP_R, LAMP_G} :
               s == SIDE_Y ? {LAMP_R, LAMP_Y} : {LAMP_R, LAMP_R};
    endfunction

endpackage

// File: rtl/traffic_phase_fsm_sync_ff.sv
// sync_ff: multi-stage flip-flop synchronizer for one asynchronous level input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: main/side phase controller driven by the phase timer flags.
// Optional PED_REQ_EN adds a pedestrian button (ped_req) and a walk lamp.
module traffic_phase_fsm
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_side,
    input  logic       tr,
    input  logic       ty,
    input  logic       tg_small,
    input  logic       tg_main,
`ifdef PED_REQ_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       T,
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic [2:0] state
);
    state_t cur, nxt;
    logic   car_s, side_req, min_done, req;

    sync_ff #(.STAGES(SYNC_STAGES)) u_car (.clk(clk), .rst(rst), .d(car_side), .q(car_s));

`ifdef PED_REQ_EN
    logic ped_s, ped_pend;
    sync_ff #(.STAGES(SYNC_STAGES)) u_ped (.clk(clk), .rst(rst), .d(ped_req), .q(ped_s));
    assign req = side_req | ped_pend;
`else
    assign req = side_req;
`endif

    always_comb begin
        nxt = ALL_R_M;
        case (cur)
            ALL_R_M: nxt = tr       ? MAIN_G  : ALL_R_M;
            MAIN_G:  nxt = (min_done | tg_main) & req ? MAIN_Y : MAIN_G;
            MAIN_Y:  nxt = ty       ? ALL_R_S : MAIN_Y;
            ALL_R_S: nxt = tr       ? SIDE_G  : ALL_R_S;
            SIDE_G:  nxt = tg_small ? SIDE_Y  : SIDE_G;
            SIDE_Y:  nxt = ty       ? ALL_R_M : SIDE_Y;
            default: nxt = ALL_R_M;
        endcase
    end

    assign T     = nxt != cur;
    assign state = cur;

    // min_done keeps main green "elapsed" after the timer wraps and tg_main drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= ALL_R_M;
            {main_r, main_y, main_g, side_r, side_y, side_g} <= {LAMP_R, LAMP_R};
            side_req <= 1'b0;
            min_done <= 1'b0;
`ifdef PED_REQ_EN
            ped_pend <= 1'b0;
            walk     <= 1'b0;
`endif
        end else begin
            cur      <= nxt;
            {main_r, main_y, main_g, side_r, side_y, side_g} <= lamps_of(nxt);
            side_req <= nxt != SIDE_G && (side_req || (car_s && cur != SIDE_G));
            min_done <= nxt == MAIN_G && (min_done || (cur == MAIN_G && tg_main));
`ifdef PED_REQ_EN
            ped_pend <= (nxt != SIDE_Y || cur == SIDE_Y) && (ped_pend || ped_s);
            walk     <= nxt == SIDE_G && (cur == SIDE_G ? walk : ped_pend);
`endif
        end
    end

endmodule
